// File: rtl/uart_reg_slave_pkg.sv
// Shared constants for the UART register slave: register addresses,
// LSR/IIR/FCR bit positions and interrupt identification codes.
package uart_reg_slave_pkg;

  localparam logic [2:0] ADDR_RBR_THR = 3'd0;
  localparam logic [2:0] ADDR_IER     = 3'd1;
  localparam logic [2:0] ADDR_IIR_FCR = 3'd2;
  localparam logic [2:0] ADDR_LCR     = 3'd3;
  localparam logic [2:0] ADDR_MCR     = 3'd4;
  localparam logic [2:0] ADDR_LSR     = 3'd5;
  localparam logic [2:0] ADDR_MSR     = 3'd6;
  localparam logic [2:0] ADDR_SCR     = 3'd7;

  localparam int LSR_DR   = 0;
  localparam int LSR_OE   = 1;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;

  localparam int FCR_FIFO_EN  = 0;
  localparam int FCR_RX_FLUSH = 1;
  localparam int FCR_TX_FLUSH = 2;

  localparam int LCR_DLAB = 7;

  typedef enum logic [3:0] {
    IIR_NONE = 4'h1,
    IIR_THRE = 4'h2,
    IIR_RDA  = 4'h4,
    IIR_RLS  = 4'h6
  } iirCode_e;

endpackage

// File: rtl/uart_reg_slave_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wrPtr_q, rdPtr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             doPush, doPop;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign count_o = wrPtr_q - rdPtr_q;
  assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

  assign doPop  = pop_i & ~empty_o;
  assign doPush = push_i & (~full_o | doPop);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_q + {{AW{1'b0}}, doPush};
      rdPtr_q <= rdPtr_q + {{AW{1'b0}}, doPop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush && !flush_i && !rst_i) begin
      mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_reg_slave.sv
// 16550-style UART register file: bus decode, line status, interrupt
// identification and RX/TX FIFOs towards an external serializer pair.
module uart_reg_slave
  import uart_reg_slave_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cs_i,
  input  logic        wr_i,
  input  logic        rd_i,
  input  logic [2:0]  a_i,
  input  logic [7:0]  din_i,
  output logic [7:0]  dout_o,
  output logic        int_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic        tx_busy_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [15:0] divisor_o,
  output logic [7:0]  lcr_out_o,
  output logic [4:0]  mcr_out_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0] lcr_q, dll_q, dlm_q, scr_q, rbrLast_q, dout_q;
  logic [3:0] ier_q;
  logic [4:0] mcr_q;
  logic       fifoMode_q, oe_q, oe_d, threPend_q, threPend_d;
  logic       txEmptyPrev_q, int_q, wrPrev_q, rdPrev_q;

  logic [7:0]  rxHead, txHead, lsr, iir, readData;
  logic [CW-1:0] rxCount, txCount;
  logic        rxFull, rxEmpty, txFull, txEmpty, rxEffFull, txEffFull;
  iirCode_e    iirCode;

  // Only the first cycle of a held strobe is an access event.
  logic wrEvent, rdEvent, dlab;
  assign wrEvent = cs_i & wr_i & ~wrPrev_q;
  assign rdEvent = cs_i & rd_i & ~rdPrev_q;
  assign dlab    = lcr_q[LCR_DLAB];

  logic thrWrite, ierWrite, fcrWrite, rbrRead, lsrRead, iirRead;
  assign thrWrite = wrEvent & (a_i == ADDR_RBR_THR) & ~dlab;
  assign ierWrite = wrEvent & (a_i == ADDR_IER) & ~dlab;
  assign fcrWrite = wrEvent & (a_i == ADDR_IIR_FCR);
  assign rbrRead  = rdEvent & (a_i == ADDR_RBR_THR) & ~dlab;
  assign lsrRead  = rdEvent & (a_i == ADDR_LSR);
  assign iirRead  = rdEvent & (a_i == ADDR_IIR_FCR);

  // Without FIFO mode both queues behave as single holding registers.
  assign rxEffFull = fifoMode_q ? rxFull : (rxCount != '0);
  assign txEffFull = fifoMode_q ? txFull : (txCount != '0);

  logic rxPop, rxPush, overrun, txPush, txPop;
  assign rxPop   = rbrRead & ~rxEmpty;
  assign rxPush  = rx_valid_i & (~rxEffFull | rxPop);
  assign overrun = rx_valid_i & rxEffFull & ~rxPop;
  assign txPush  = thrWrite & ~txEffFull;
  assign txPop   = ~txEmpty & tx_ready_i;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) rxFifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(rxPush), .pop_i(rxPop),
    .flush_i(fcrWrite & din_i[FCR_RX_FLUSH]), .wdata_i(rx_data_i),
    .rdata_o(rxHead), .full_o(rxFull), .empty_o(rxEmpty), .count_o(rxCount)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) txFifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(txPush), .pop_i(txPop),
    .flush_i(fcrWrite & din_i[FCR_TX_FLUSH]), .wdata_i(din_i),
    .rdata_o(txHead), .full_o(txFull), .empty_o(txEmpty), .count_o(txCount)
  );

  always_comb begin
    lsr           = '0;
    lsr[LSR_DR]   = ~rxEmpty;
    lsr[LSR_OE]   = oe_q;
    lsr[LSR_THRE] = txEmpty;
    lsr[LSR_TEMT] = txEmpty & ~tx_busy_i;
  end

  always_comb begin
    iirCode = IIR_NONE;
    if (oe_q && ier_q[2])            iirCode = IIR_RLS;
    else if (!rxEmpty && ier_q[0])   iirCode = IIR_RDA;
    else if (threPend_q && ier_q[1]) iirCode = IIR_THRE;
    iir = {{2{fifoMode_q}}, 2'b00, iirCode};
  end

  // An overrun in the same cycle as the LSR read keeps OE set.
  always_comb begin
    oe_d = oe_q;
    if (lsrRead) oe_d = 1'b0;
    if (overrun) oe_d = 1'b1;
  end

  always_comb begin
    threPend_d = threPend_q;
    if (iirRead && (iirCode == IIR_THRE)) threPend_d = 1'b0;
    if ((txEmpty && !txEmptyPrev_q) || (ierWrite && din_i[1] && !ier_q[1] && txEmpty))
      threPend_d = 1'b1;
    if (thrWrite) threPend_d = 1'b0;
  end

  always_comb begin
    readData = 8'h00;
    case (a_i)
      ADDR_RBR_THR: readData = dlab ? dll_q : (rxEmpty ? rbrLast_q : rxHead);
      ADDR_IER:     readData = dlab ? dlm_q : {4'b0000, ier_q};
      ADDR_IIR_FCR: readData = iir;
      ADDR_LCR:     readData = lcr_q;
      ADDR_MCR:     readData = {3'b000, mcr_q};
      ADDR_LSR:     readData = lsr;
      ADDR_MSR:     readData = 8'h00;
      ADDR_SCR:     readData = scr_q;
      default:      readData = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lcr_q <= '0; dll_q <= '0; dlm_q <= '0; ier_q <= '0; fifoMode_q <= 1'b0;
      mcr_q <= '0; scr_q <= '0; oe_q <= 1'b0; threPend_q <= 1'b0;
      txEmptyPrev_q <= 1'b1; rbrLast_q <= '0; dout_q <= '0; int_q <= 1'b0;
      wrPrev_q <= 1'b0; rdPrev_q <= 1'b0;
    end else begin
      wrPrev_q      <= cs_i & wr_i;
      rdPrev_q      <= cs_i & rd_i;
      oe_q          <= oe_d;
      threPend_q    <= threPend_d;
      txEmptyPrev_q <= txEmpty;
      int_q         <= ~iir[0];
      if (rdEvent) dout_q <= readData;
      if (rxPop) rbrLast_q <= rxHead;
      if (wrEvent) begin
        case (a_i)
          ADDR_RBR_THR: if (dlab) dll_q <= din_i;
          ADDR_IER:     if (dlab) dlm_q <= din_i; else ier_q <= din_i[3:0];
          ADDR_IIR_FCR: fifoMode_q <= din_i[FCR_FIFO_EN];
          ADDR_LCR:     lcr_q <= din_i;
          ADDR_MCR:     mcr_q <= din_i[4:0];
          ADDR_SCR:     scr_q <= din_i;
          default:      ;
        endcase
      end
    end
  end

  assign dout_o     = dout_q;
  assign int_o      = int_q;
  assign tx_data_o  = txHead;
  assign tx_valid_o = ~txEmpty;
  assign divisor_o  = {dlm_q, dll_q};
  assign lcr_out_o  = lcr_q;
  assign mcr_out_o  = mcr_q;

endmodule

// File: tb/tb_uart_reg_slave.sv
// Directed bench for uart_reg_slave: configuration, TX/RX paths, overrun,
// THRE interrupt and reset during an access.
module tb_uart_reg_slave;

  logic        clock = 1'b0;
  logic        reset, csSig, wrSig, rdSig, txReady, txBusy, rxValid;
  logic [2:0]  addr;
  logic [7:0]  dinSig, doutSig, txData, rxData, lcrOut, readVal;
  logic        intSig, txValid;
  logic [15:0] divisor;
  logic [4:0]  mcrOut;

  int checkCount = 0;
  int passCount  = 0;

  uart_reg_slave dut (
    .clk_i(clock), .rst_i(reset), .cs_i(csSig), .wr_i(wrSig), .rd_i(rdSig),
    .a_i(addr), .din_i(dinSig), .dout_o(doutSig), .int_o(intSig),
    .tx_data_o(txData), .tx_valid_o(txValid), .tx_ready_i(txReady),
    .tx_busy_i(txBusy), .rx_data_i(rxData), .rx_valid_i(rxValid),
    .divisor_o(divisor), .lcr_out_o(lcrOut), .mcr_out_o(mcrOut)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // One-cycle bus write.
  task automatic applyStimulus(input logic [2:0] regAddr, input logic [7:0] data);
    @(negedge clock);
    csSig = 1'b1; wrSig = 1'b1; addr = regAddr; dinSig = data;
    @(negedge clock);
    csSig = 1'b0; wrSig = 1'b0;
  endtask

  task automatic readReg(input logic [2:0] regAddr, output logic [7:0] data);
    @(negedge clock);
    csSig = 1'b1; rdSig = 1'b1; addr = regAddr;
    @(negedge clock);
    csSig = 1'b0; rdSig = 1'b0;
    data = doutSig;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulseTxReady();
    @(negedge clock); txReady = 1'b1;
    @(negedge clock); txReady = 1'b0;
  endtask

  initial begin
    reset = 1'b1; csSig = 0; wrSig = 0; rdSig = 0; addr = 0; dinSig = 0;
    txReady = 0; txBusy = 0; rxValid = 0; rxData = 0;
    waitCycles(3);
    checkOutput("rst_dout", doutSig, 8'h00);
    checkOutput("rst_int", intSig, 1'b0);
    checkOutput("rst_txvalid", txValid, 1'b0);
    checkOutput("rst_divisor", divisor, 16'h0000);
    checkOutput("rst_lcr", lcrOut, 8'h00);
    checkOutput("rst_mcr", mcrOut, 5'h00);
    reset = 1'b0;
    readReg(3'd5, readVal); checkOutput("rst_lsr", readVal, 8'h60);
    readReg(3'd2, readVal); checkOutput("rst_iir", readVal, 8'h01);

    // Configuration
    applyStimulus(3'd3, 8'h83);
    applyStimulus(3'd0, 8'h11);
    applyStimulus(3'd1, 8'h00);
    applyStimulus(3'd3, 8'h03);
    applyStimulus(3'd2, 8'h00);
    applyStimulus(3'd1, 8'h03);
    checkOutput("cfg_divisor", divisor, 16'h0011);
    checkOutput("cfg_lcr", lcrOut, 8'h03);
    readReg(3'd1, readVal); checkOutput("cfg_ier", readVal, 8'h03);
    readReg(3'd2, readVal); checkOutput("cfg_iir_thre", readVal, 8'h02);
    @(negedge clock);
    csSig = 1; wrSig = 1; addr = 3'd4; dinSig = 8'h05;
    @(negedge clock); dinSig = 8'h0A;
    @(negedge clock); dinSig = 8'h1F;
    @(negedge clock); csSig = 0; wrSig = 0;
    checkOutput("held_write_mcr", mcrOut, 5'h05);

    // TX path
    applyStimulus(3'd0, 8'h43);
    checkOutput("tx_valid", txValid, 1'b1);
    checkOutput("tx_data", txData, 8'h43);
    readReg(3'd5, readVal); checkOutput("tx_lsr_full", readVal, 8'h00);
    txBusy = 1'b1;
    pulseTxReady();
    readReg(3'd5, readVal); checkOutput("tx_lsr_busy", readVal, 8'h20);
    txBusy = 1'b0;
    readReg(3'd5, readVal); checkOutput("tx_lsr_idle", readVal, 8'h60);

    // RX path
    applyStimulus(3'd1, 8'h01);
    applyStimulus(3'd2, 8'h01);
    waitCycles(2);
    checkOutput("rx_int_idle", intSig, 1'b0);
    @(negedge clock); rxData = 8'h20; rxValid = 1'b1;
    @(negedge clock); rxValid = 1'b0;
    readReg(3'd5, readVal); checkOutput("rx_lsr", readVal, 8'h61);
    checkOutput("rx_int", intSig, 1'b1);
    readReg(3'd2, readVal); checkOutput("rx_iir", readVal, 8'hC4);
    readReg(3'd0, readVal); checkOutput("rx_rbr", readVal, 8'h20);
    readReg(3'd5, readVal); checkOutput("rx_lsr_after", readVal, 8'h60);

    // Overrun with a full 16-entry FIFO
    applyStimulus(3'd1, 8'h05);
    for (int i = 0; i < 17; i++) begin
      @(negedge clock); rxData = 8'(i); rxValid = 1'b1;
    end
    @(negedge clock); rxValid = 1'b0;
    readReg(3'd2, readVal); checkOutput("ovr_iir", readVal, 8'hC6);
    readReg(3'd5, readVal); checkOutput("ovr_lsr", readVal, 8'h63);
    readReg(3'd5, readVal); checkOutput("ovr_lsr_reread", readVal, 8'h61);
    for (int i = 0; i < 16; i++) begin
      readReg(3'd0, readVal);
      checkOutput($sformatf("ovr_rbr%0d", i), readVal, 16'(i));
    end
    readReg(3'd5, readVal); checkOutput("ovr_lsr_empty", readVal, 8'h60);
    readReg(3'd0, readVal); checkOutput("rbr_empty_last", readVal, 8'h0F);
    readReg(3'd5, readVal); checkOutput("rbr_empty_lsr", readVal, 8'h60);

    // THRE interrupt
    applyStimulus(3'd1, 8'h02);
    waitCycles(2);
    checkOutput("thre_int_set", intSig, 1'b1);
    readReg(3'd2, readVal); checkOutput("thre_iir", readVal, 8'hC2);
    waitCycles(2);
    checkOutput("thre_int_clr", intSig, 1'b0);
    applyStimulus(3'd1, 8'h00);
    applyStimulus(3'd1, 8'h02);
    waitCycles(2);
    checkOutput("thre_ier_rise", intSig, 1'b1);
    readReg(3'd2, readVal); checkOutput("thre_iir2", readVal, 8'hC2);
    applyStimulus(3'd0, 8'h55);
    waitCycles(2);
    checkOutput("thre_int_thr", intSig, 1'b0);
    checkOutput("thre_txdata", txData, 8'h55);
    pulseTxReady();
    waitCycles(3);
    checkOutput("thre_int_drain", intSig, 1'b1);

    // Non-FIFO mode: second THR write is discarded
    applyStimulus(3'd2, 8'h00);
    applyStimulus(3'd0, 8'h61);
    applyStimulus(3'd0, 8'h62);
    checkOutput("tx1_data", txData, 8'h61);
    pulseTxReady();
    checkOutput("tx1_discard", txValid, 1'b0);

    // Strobe held across reset release counts as a new write
    @(negedge clock); reset = 1; csSig = 1; wrSig = 1; addr = 3'd7; dinSig = 8'h33;
    @(negedge clock); reset = 0;
    @(negedge clock); csSig = 0; wrSig = 0;
    readReg(3'd7, readVal); checkOutput("rearm_scr", readVal, 8'h33);

    // Reset during the write cycle aborts it
    @(negedge clock); reset = 1; csSig = 1; wrSig = 1; addr = 3'd7; dinSig = 8'h5A;
    @(negedge clock); reset = 0; csSig = 0; wrSig = 0;
    readReg(3'd7, readVal); checkOutput("rstwr_scr", readVal, 8'h00);
    readReg(3'd5, readVal); checkOutput("rstwr_lsr", readVal, 8'h60);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/uart_reg_slave.md
UART_REG_SLAVE -- requirements
Module: uart_reg_slave

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, SHALL set the RX and TX FIFO depth; legal values are powers of two, 2..64.
REQ-002 clk  in  1  — the single clock; every register updates on its rising edge.
REQ-003 rst  in  1  — synchronous, active-high reset.
REQ-004 cs, wr, rd  in  1 each  — bus select, write strobe and read strobe.
REQ-005 a  in  3  — register address.
REQ-006 din  in  8  — write data; dout  out  8  — registered read data.
REQ-007 int  out  1  — interrupt request, active high.
REQ-008 tx_data  out  8, tx_valid  out  1, tx_ready  in  1  — TX FIFO head towards the serializer.
REQ-009 tx_busy  in  1  — high while the serializer is shifting.
REQ-010 rx_data  in  8, rx_valid  in  1  — one-cycle byte pulse from the deserializer.
REQ-011 divisor  out  16  — {DLM, DLL}; lcr_out  out  8; mcr_out  out  5.

Function
REQ-012 Access event: a write SHALL commit only in the first cycle in which cs&wr is high. Further cycles with cs&wr held high SHALL be ignored until cs&wr drops.
REQ-013 Read event: the first cycle in which cs&rd is high SHALL latch the read data into dout one cycle later. Read side effects SHALL occur only on that first cycle.
REQ-014 dout SHALL hold its value between read events.
REQ-015 Address map, DLAB = LCR[7]:
- 0: read RBR (pops RX FIFO) / write THR (pushes TX FIFO); DLAB=1: DLL.
- 1: IER[3:0], upper bits read 0; DLAB=1: DLM.
- 2: read IIR / write FCR.
- 3: LCR.
- 4: MCR[4:0].
- 5: LSR, read-only; writes ignored.
- 6: MSR, reads 0x00.
- 7: SCR.
REQ-016 FCR: bit0 SHALL set FIFO mode. With bit0=0, the effective depth of both FIFOs SHALL be 1. Bit1 SHALL flush the RX FIFO; bit2 SHALL flush the TX FIFO. Both flush bits self-clear.
REQ-017 LSR SHALL read {1'b0, TEMT, THRE, 3'b000, OE, DR}:
- DR = RX FIFO not empty.
- OE = overrun sticky bit.
- THRE = TX FIFO empty.
- TEMT = THRE & ~tx_busy.
REQ-018 rx_valid when the RX FIFO is at effective full SHALL drop the byte and set OE. A pop in the same cycle SHALL instead make room, so the byte is accepted.
REQ-019 OE SHALL clear on an LSR read event; an overrun in the same cycle SHALL win.
REQ-020 A RBR read with the RX FIFO empty SHALL return the last popped byte and SHALL NOT change FIFO state.
REQ-021 A THR write with the TX FIFO full SHALL be discarded.
REQ-022 tx_valid SHALL equal TX FIFO not empty. A pop SHALL occur on tx_valid&tx_ready, and tx_data SHALL be valid in the same cycle.
REQ-023 IIR SHALL encode, by priority:
- 0x06: OE & IER[2].
- 0x04: DR & IER[0].
- 0x02: thre_pend & IER[1].
- 0x01: none.
Bits 7:6 SHALL read 11 when FCR[0] is set.
REQ-024 thre_pend SHALL set on the TX FIFO becoming empty, or on an IER[1] write of 0→1 while the FIFO is empty. It SHALL clear on a THR write, or on an IIR read event that returned 0x02.
REQ-025 int SHALL be registered and SHALL equal ~IIR[0] one cycle after the source changes.
REQ-026 The FIFOs SHALL use binary pointers one bit wider than log2(FIFO_DEPTH) for full/empty detection, with wrap-around modulo 2*FIFO_DEPTH.

Reset
REQ-027 While rst is high, all registers SHALL reset: LCR, DLL, DLM, IER, FCR, MCR and SCR to 0x00, OE=0, thre_pend=0, both FIFOs empty.
REQ-028 Reset outputs SHALL be dout=0x00, int=0, tx_valid=0, divisor=0x0000, lcr_out=0x00 and mcr_out=0x00. LSR SHALL read 0x60 after reset; IIR SHALL read 0x01.
REQ-029 rst asserted during an access SHALL abort the access. The access-edge detector SHALL re-arm, so a strobe still high after reset SHALL count as a new event.

Structure
REQ-030 A shared package SHALL hold the register address constants, LSR/IIR/FCR bit positions and IIR codes.
REQ-031 One sub-module, sync_fifo (parameterised width/depth, push/pop/flush, full/empty/count), SHALL be instantiated twice.

Verification
REQ-032 Config: write LCR=0x83, DLL=0x11, DLM=0x00, LCR=0x03, FCR=0x00, IER=0x03 → divisor=0x0011, lcr_out=0x03, address 1 reads 0x03; with wr held 3 cycles, exactly one write commits.
REQ-033 TX: write THR=0x43 with tx_ready=0 → tx_valid=1, tx_data=0x43, LSR=0x00. Then tx_ready=1 for one cycle with tx_busy=1 → LSR=0x20. Then tx_busy=0 → LSR=0x60.
REQ-034 RX: rx_valid pulse with 0x20 → LSR=0x61, int=1, IIR=0xC4 (FCR=0x01). RBR read returns 0x20; LSR then reads 0x60.
REQ-035 Overrun: FCR=0x01, FIFO_DEPTH=16, push 17 bytes 0x00..0x10 → LSR=0x63, IIR=0xC6 (IER=0x05). LSR re-read reads 0x61. 16 RBR reads return 0x00..0x0F.
REQ-036 THRE interrupt: IER=0x02 with the TX FIFO empty → IIR=0x02 and int=1. IIR read → int=0. THR write then drain → int=1 again.
REQ-037 Reset mid-write: rst during the cs&wr cycle of SCR=0x5A → SCR reads 0x00, LSR reads 0x60.
